// File: rtl/aidan_mcnay_debouncer_array_pkg.sv
// Shared limits and counter-width helper for the debouncer array.
// Imported by the channel unit and the array top.
package aidan_mcnay_debouncer_array_pkg;

  localparam int SYNC_STAGES_MAX   = 3;
  localparam int STABLE_CYCLES_MIN = 2;

  function automatic int cnt_w(input int stable);
    int w;
    w = $clog2(stable);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/aidan_mcnay_debounce_ch.sv
// Single debounce channel: optional synchroniser, stability
// counter, registered level and one-cycle edge pulses.
module aidan_mcnay_debounce_ch
  import aidan_mcnay_debouncer_array_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_w(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync <= '0;
      end else begin
        sync[0] <= in;
        for (int k = 1; k < SYNC_STAGES; k++)
          sync[k] <= sync[k-1];
      end
    end

    assign s = sync[SYNC_STAGES-1];
  end

  // Any sample matching the current level restarts qualification.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (s == out) begin
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt  <= '0;
      out  <= s;
      rise <= s;
      fall <= ~s;
    end else begin
      cnt  <= cnt + 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/aidan_mcnay_debouncer_array.sv
// Array of independent debounce channels with a combined
// change flag for the downstream control logic.
module aidan_mcnay_debouncer_array
  import aidan_mcnay_debouncer_array_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);

  if (STABLE_CYCLES < STABLE_CYCLES_MIN) begin : g_bad_stable
    $error("STABLE_CYCLES below minimum");
  end
  if (SYNC_STAGES > SYNC_STAGES_MAX || SYNC_STAGES < 0)
  begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("N_CH must be at least 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    aidan_mcnay_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign any_change = |(rise | fall);

endmodule

// File: tb/tb_aidan_mcnay_debouncer_array.sv
// Scoreboard bench: window-based reference model for the default
// array, plus latency checks on two other parameter sets.
module tb_aidan_mcnay_debouncer_array;

  localparam int SA = 2;
  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_a;
  logic [3:0] out_a, rise_a, fall_a;
  logic       any_a;
  logic [0:0] in_b, out_b, rise_b, fall_b;
  logic       any_b;
  logic [0:0] in_c, out_c, rise_c, fall_c;
  logic       any_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aidan_mcnay_debouncer_array u_a (
    .clk(clk), .reset(reset), .in(in_a), .out(out_a),
    .rise(rise_a), .fall(fall_a), .any_change(any_a)
  );

  aidan_mcnay_debouncer_array #(
    .N_CH(1), .STABLE_CYCLES(2), .SYNC_STAGES(0)
  ) u_b (
    .clk(clk), .reset(reset), .in(in_b), .out(out_b),
    .rise(rise_b), .fall(fall_b), .any_change(any_b)
  );

  aidan_mcnay_debouncer_array #(
    .N_CH(1), .STABLE_CYCLES(17), .SYNC_STAGES(2)
  ) u_c (
    .clk(clk), .reset(reset), .in(in_c), .out(out_c),
    .rise(rise_c), .fall(fall_c), .any_change(any_c)
  );

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] inq[$];
  logic [3:0] win[$];
  logic [3:0] mout, mrise, mfall;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    inq = {};
    win = {};
    for (int k = 0; k < SA; k++) inq.push_back(4'h0);
    for (int k = 0; k < SC; k++) win.push_back(4'h0);
    mout  = '0;
    mrise = '0;
    mfall = '0;
  endtask

  // Output flips once the last SC delayed samples all differ from it.
  task automatic model_edge(input logic [3:0] v, input logic r);
    logic [3:0] s, d;
    bit         diff;
    if (r) begin
      model_reset();
    end else begin
      inq.push_back(v);
      s = inq.pop_front();
      win.push_back(s);
      d = win.pop_front();
      for (int ch = 0; ch < 4; ch++) begin
        diff = 1;
        foreach (win[k]) if (win[k][ch] == mout[ch]) diff = 0;
        if (diff) begin
          mout[ch]  = s[ch];
          mrise[ch] = s[ch];
          mfall[ch] = ~s[ch];
        end else begin
          mrise[ch] = 1'b0;
          mfall[ch] = 1'b0;
        end
      end
    end
    sb.push_back('{mout, mrise, mfall, |(mrise | mfall)});
  endtask

  task automatic step(input logic [3:0] v, input logic r);
    in_a  = v;
    reset = r;
    @(posedge clk);
    model_edge(v, r);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("scoreboard out/rise/fall/any",
          {19'd0, out_a, rise_a, fall_a, any_a}, {19'd0, e});
    end
  end

  int lat;
  bit seen;
  logic [3:0] v;

  initial begin
    model_reset();
    in_a = '0; in_b = '0; in_c = '0; reset = 1'b1;
    step(4'h0, 1'b1);
    step(4'h0, 1'b1);
    chk("reset out", {28'd0, out_a}, 32'd0);
    chk("reset any", {31'd0, any_a}, 32'd0);
    step(4'h0, 1'b0);

    // Clean step on channel 0
    lat = 0;
    do begin
      step(4'h1, 1'b0);
      lat++;
    end while (!out_a[0] && lat < 20);
    chk("clean step latency", lat, 6);
    chk("clean step rise", {28'd0, rise_a}, 32'h1);
    chk("clean step any", {31'd0, any_a}, 32'd1);
    step(4'h1, 1'b0);
    chk("rise one cycle", {28'd0, rise_a}, 32'h0);

    // Glitch rejection on channel 1
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      v = (k < 3 || (k > 3 && k < 7)) ? 4'h3 : 4'h1;
      step(v, 1'b0);
      if (out_a[1] || rise_a[1]) seen = 1;
    end
    chk("glitch no flip", {31'd0, seen}, 32'd0);

    // Falling edge on channel 2, then fast toggling
    for (int k = 0; k < 8; k++) step(4'h5, 1'b0);
    chk("ch2 high", {31'd0, out_a[2]}, 32'd1);
    lat = 0;
    do begin
      step(4'h1, 1'b0);
      lat++;
    end while (out_a[2] && lat < 20);
    chk("fall latency", lat, 6);
    chk("fall pulse", {28'd0, fall_a}, 32'h4);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step(((k / 2) % 2) ? 4'h5 : 4'h1, 1'b0);
      if (out_a[2]) seen = 1;
    end
    chk("toggle no flip", {31'd0, seen}, 32'd0);

    // Simultaneous rise on all channels
    step(4'h0, 1'b1);
    for (int k = 0; k < 6; k++) step(4'hf, 1'b0);
    chk("simul rise", {28'd0, rise_a}, 32'hf);
    chk("simul out", {28'd0, out_a}, 32'hf);

    // Reset mid-qualification
    step(4'h0, 1'b1);
    for (int k = 0; k < 4; k++) step(4'h8, 1'b0);
    step(4'h8, 1'b1);
    chk("mid reset out", {28'd0, out_a}, 32'h0);
    lat = 0;
    do begin
      step(4'h8, 1'b0);
      lat++;
    end while (!out_a[3] && lat < 20);
    chk("post reset latency", lat, 6);
    chk("post reset rise", {28'd0, rise_a}, 32'h8);

    // Randomised traffic through the scoreboard
    v = '0;
    for (int k = 0; k < 2000; k++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(4) == 0) v[ch] = ~v[ch];
      step(v, ($urandom_range(199) == 0));
    end

    // Parameter sweep instances
    step(4'h0, 1'b1);
    in_b = 1'b1;
    in_c = 1'b1;
    lat = 0;
    begin
      int lb, lc;
      lb = -1; lc = -1;
      for (int k = 1; k <= 40; k++) begin
        step(4'h0, 1'b0);
        if (out_b[0] && lb < 0) begin
          lb = k;
          chk("sweep b rise", {31'd0, rise_b}, 32'd1);
        end
        if (out_c[0] && lc < 0) begin
          lc = k;
          chk("sweep c rise", {31'd0, any_c}, 32'd1);
        end
      end
      chk("sweep b latency", lb, 2);
      chk("sweep c latency", lc, 19);
    end

    // Long near-qualifying glitches must not flip or wrap
    seen = 0;
    for (int r = 0; r < 3; r++) begin
      in_c = 1'b0;
      for (int k = 0; k < 16; k++) step(4'h0, 1'b0);
      in_c = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step(4'h0, 1'b0);
        if (!out_c[0] || fall_c[0]) seen = 1;
      end
    end
    for (int k = 0; k < 20; k++) begin
      step(4'h0, 1'b0);
      if (!out_c[0] || fall_c[0]) seen = 1;
    end
    chk("c no overflow flip", {31'd0, seen}, 32'd0);
    in_c = 1'b0;
    lat = 0;
    do begin
      step(4'h0, 1'b0);
      lat++;
    end while (out_c[0] && lat < 40);
    chk("c fall latency", lat, 19);
    chk("c fall pulse", {31'd0, fall_c}, 32'd1);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
